ysyx_22050078_ifu_fq: RTL and testbench
=======================================

YSYX_22050078_IFU_FQ -- requirements
Module: ysyx_22050078_ifu_fq

Interface
REQ-001 Parameter CPU_WIDTH, 64, address and memory data width in bits (32 or 64) SHALL be supported.
REQ-002 Parameter INST_WIDTH, 32, instruction width delivered to IDU SHALL be supported.
REQ-003 Parameter RESET_PC, 64'h8000_0000, first fetch address after reset SHALL be supported.
REQ-004 Parameter FQ_DEPTH, 4, fetch-queue entries, power of two, at least 2, SHALL be supported.
REQ-005 Ports SHALL be exactly as follows.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- redirect_valid  input  1  flush and restart fetch (branch/jump/exception).
- redirect_pc  input  CPU_WIDTH  new fetch address.
- mem_req_valid  output  1  fetch request to instruction memory.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  CPU_WIDTH  fetch address, 4-byte aligned.
- mem_rsp_valid  input  1  memory read data valid.
- mem_rsp_data  input  CPU_WIDTH  memory read word.
- inst_valid  output  1  queue head valid toward IDU.
- inst_ready  input  1  IDU consumes head.
- inst_out  output  INST_WIDTH  head instruction.
- inst_pc  output  CPU_WIDTH  head instruction pc.
- fq_count  output  $clog2(FQ_DEPTH)+1  occupied entries.

Function
REQ-006 FSM states SHALL be IDLE, REQ, WAIT, DROP_REQ, DROP_WAIT; mem_req_valid=1 only in REQ and DROP_REQ.
REQ-007 IDLE->REQ SHALL occur when fq_count plus in-flight (0 in IDLE) < FQ_DEPTH and no redirect.
REQ-008 REQ->WAIT on mem_req_valid&mem_req_ready; fetch_pc SHALL advance by 4 at acceptance; only one request outstanding.
REQ-009 mem_req_addr SHALL equal fetch_pc and remain stable while mem_req_valid&!mem_req_ready; a request SHALL never be withdrawn.
REQ-010 WAIT->IDLE on mem_rsp_valid; entry {pc, inst} SHALL be written to queue tail the same edge.
REQ-011 inst SHALL be mem_rsp_data[31:0] when CPU_WIDTH=32; when 64, bits [63:32] if pc[2]=1 else [31:0].
REQ-012 Queue SHALL be a FQ_DEPTH circular buffer with wrapping head/tail pointers; inst_valid=(fq_count!=0); inst_out/inst_pc driven from head registers.
REQ-013 Simultaneous enqueue and dequeue SHALL leave fq_count unchanged; enqueue into a full queue SHALL be impossible by REQ-007 credit rule.
REQ-014 redirect_valid SHALL, at the next edge: fq_count=0, pointers reset, fetch_pc=redirect_pc with bits[1:0] forced to 0; redirect wins over a same-cycle dequeue.
REQ-015 Redirect in IDLE or WAIT-with-mem_rsp_valid SHALL go to IDLE; in WAIT without response ->DROP_WAIT; in REQ with handshake ->DROP_WAIT; in REQ without handshake ->DROP_REQ (addr held).
REQ-016 DROP_REQ->DROP_WAIT on handshake; DROP_WAIT->IDLE on mem_rsp_valid; dropped responses SHALL NOT enter the queue or advance fetch_pc.
REQ-017 Further redirects in DROP states SHALL update fetch_pc only; state unchanged.
REQ-018 Latency: response at edge N SHALL make inst_valid=1 after edge N (visible cycle N+1); fq_count/inst_valid SHALL deassert the cycle after a redirect.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE, fetch_pc=RESET_PC, fq_count=0, pointers 0, mem_req_valid=0, inst_valid=0, mem_req_addr=RESET_PC, inst_out=0, inst_pc=0.
REQ-020 Reset mid-request or mid-response SHALL discard the transaction; the first request after release SHALL be RESET_PC at first edge.

Verification
REQ-021 Release reset, mem_req_ready=1, 1-cycle response 0x00000013 -> mem_req_addr 0x80000000, then 0x80000004; inst_out=0x00000013, inst_pc=0x80000000.
REQ-022 inst_ready=0, FQ_DEPTH=4, always-ready memory -> exactly 4 requests (0x80000000..0x8000000C), fq_count=4, mem_req_valid stays 0.
REQ-023 mem_req_ready=0 for 5 cycles -> mem_req_addr stable 0x80000000, mem_req_valid held 5 cycles.
REQ-024 Redirect to 0x80001002 while WAIT -> fq_count=0 next cycle, pending response dropped, next request 0x80001000.
REQ-025 CPU_WIDTH=64, mem_rsp_data=0xAAAAAAAA_BBBBBBBB at pc 0x80000004 -> inst_out=0xAAAAAAAA.
REQ-026 Full queue with simultaneous dequeue and response -> fq_count unchanged, FIFO order preserved across pointer wrap.

Source files
------------

// File: rtl/ysyx_22050078_ifu_fq.sv
// ysyx_22050078_ifu_fq: instruction fetch unit with one outstanding memory fetch feeding a circular fetch queue
module ysyx_22050078_ifu_fq #(
    parameter int          CPU_WIDTH  = 64,
    parameter int          INST_WIDTH = 32,
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int          FQ_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      redirect_valid,
    input  logic [CPU_WIDTH-1:0]      redirect_pc,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [CPU_WIDTH-1:0]      mem_req_addr,
    input  logic                      mem_rsp_valid,
    input  logic [CPU_WIDTH-1:0]      mem_rsp_data,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [INST_WIDTH-1:0]     inst_out,
    output logic [CPU_WIDTH-1:0]      inst_pc,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FQ_DEPTH);
    localparam logic [CPU_WIDTH-1:0] PC0 = RESET_PC[CPU_WIDTH-1:0];

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP_REQ, DROP_WAIT} state_t;

    state_t                r_state, w_next;
    logic [CPU_WIDTH-1:0]  r_fetch_pc, r_req_addr, w_fetch_pc_nxt;
    logic [CPU_WIDTH-1:0]  r_q_pc   [FQ_DEPTH];
    logic [INST_WIDTH-1:0] r_q_inst [FQ_DEPTH];
    logic [AW-1:0]         r_head, r_tail;
    logic [AW:0]           r_count;
    logic                  w_hs, w_enq, w_deq;
    logic [INST_WIDTH-1:0] w_inst;

    assign mem_req_valid = (r_state == REQ) || (r_state == DROP_REQ);
    // a redirect while a request is pending moves fetch_pc, so the held address comes from r_req_addr
    assign mem_req_addr  = (r_state == DROP_REQ) ? r_req_addr : r_fetch_pc;
    assign w_hs          = mem_req_valid && mem_req_ready;
    assign w_enq         = (r_state == WAIT) && mem_rsp_valid && !redirect_valid;
    assign w_deq         = inst_valid && inst_ready && !redirect_valid;
    assign inst_valid    = r_count != '0;
    assign inst_out      = r_q_inst[r_head];
    assign inst_pc       = r_q_pc[r_head];
    assign fq_count      = r_count;

    generate
        if (CPU_WIDTH == 64) begin : g_w64
            assign w_inst = r_req_addr[2] ? mem_rsp_data[32 +: INST_WIDTH] : mem_rsp_data[INST_WIDTH-1:0];
        end else begin : g_w32
            assign w_inst = mem_rsp_data[INST_WIDTH-1:0];
        end
    endgenerate

    assign w_fetch_pc_nxt = redirect_valid ? {redirect_pc[CPU_WIDTH-1:2], 2'b00} :
                            (r_state == REQ && w_hs) ? r_fetch_pc + CPU_WIDTH'(4) : r_fetch_pc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = (!redirect_valid && r_count != FULL) ? REQ : IDLE;
            REQ:       w_next = w_hs ? (redirect_valid ? DROP_WAIT : WAIT) : (redirect_valid ? DROP_REQ : REQ);
            WAIT:      w_next = mem_rsp_valid ? IDLE : (redirect_valid ? DROP_WAIT : WAIT);
            DROP_REQ:  w_next = w_hs ? DROP_WAIT : DROP_REQ;
            DROP_WAIT: w_next = mem_rsp_valid ? IDLE : DROP_WAIT;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= PC0;
            r_req_addr <= PC0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_inst[i] <= '0;
            end
        end else begin
            r_state    <= w_next;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (r_state == REQ) r_req_addr <= r_fetch_pc;
            if (w_enq) begin
                r_q_pc[r_tail]   <= r_req_addr;
                r_q_inst[r_tail] <= w_inst;
            end
            if (redirect_valid) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) r_tail <= r_tail + AW'(1);
                if (w_deq) r_head <= r_head + AW'(1);
                r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050078_ifu_fq.sv
// tb_ysyx_22050078_ifu_fq: directed and randomized checks of the fetch queue against a queue-based reference model
module tb_ysyx_22050078_ifu_fq;
    localparam int          D   = 4;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        redirect_valid = 1'b0, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0, inst_ready = 1'b0;
    logic [63:0] redirect_pc = '0, mem_rsp_data = '0;
    logic        mem_req_valid, inst_valid;
    logic [63:0] mem_req_addr, inst_pc;
    logic [31:0] inst_out;
    logic [$clog2(D):0] fq_count;

    ysyx_22050078_ifu_fq dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [63:0] pc; logic [31:0] inst;} ent_t;
    ent_t        q[$];
    int          n_cmp = 0, n_bad = 0;
    logic [63:0] exp_pc, held_addr, out_addr, fixed_data;
    bit          held, outst, out_live, pend_drop, fixed_en;
    int          lat, lat_cfg, n_hs = 0, n_both = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return fixed_en ? fixed_data : {a[31:0] ^ 32'hA5A5_0000, a[31:0] + 32'h1357};
    endfunction

    task automatic model_reset();
        q.delete();
        exp_pc = RPC;
        held = 0; outst = 0; out_live = 0; pend_drop = 0; lat = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; inst_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; redirect_valid = 0;
        #1;
        chk("rst_reqv", mem_req_valid, 0);
        chk("rst_addr", mem_req_addr, RPC);
        chk("rst_instv", inst_valid, 0);
        chk("rst_cnt", fq_count, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_ipc", inst_pc, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // one clock: check the present outputs, drive inputs, predict the edge, advance to the next negedge
    task automatic step(input bit ir, input bit mr, input bit rv, input logic [63:0] rp);
        bit hs, rsp, deq;
        logic [63:0] w;
        chk("count", fq_count, q.size());
        chk("instv", inst_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("inst", inst_out, q[0].inst);
            chk("ipc", inst_pc, q[0].pc);
        end
        if (mem_req_valid) begin
            if (held) chk("addr_hold", mem_req_addr, held_addr);
            else begin
                chk("addr", mem_req_addr, exp_pc);
                chk("one_outst", outst, 0);
                chk("credit", q.size() < D, 1);
                held_addr = exp_pc;
            end
        end
        inst_ready = ir; mem_req_ready = mr; redirect_valid = rv; redirect_pc = rp;
        rsp = outst && lat == 0;
        w = mem_word(out_addr);
        mem_rsp_valid = rsp;
        mem_rsp_data = rsp ? w : {$urandom, $urandom};
        hs = mem_req_valid && mr;
        deq = ir && q.size() != 0 && !rv;
        if (outst && !rsp) lat--;
        if (deq) void'(q.pop_front());
        if (rsp) begin
            if (out_live && !rv) begin
                q.push_back('{pc: out_addr, inst: out_addr[2] ? w[63:32] : w[31:0]});
                if (deq) n_both++;
            end
            outst = 0;
        end
        if (hs) begin
            outst = 1;
            out_addr = held_addr;
            out_live = !pend_drop && !rv;
            lat = lat_cfg < 0 ? int'($urandom_range(0, 3)) : lat_cfg;
            n_hs++;
            if (out_live) exp_pc += 64'd4;
        end
        if (rv) begin
            q.delete();
            exp_pc = {rp[63:2], 2'b00};
            if (outst) out_live = 0;
        end
        pend_drop = mem_req_valid && !mr && (pend_drop || rv);
        held = mem_req_valid && !mr;
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input bit ir, input int budget);
        int n = 0;
        while (!mem_req_valid && n < budget) begin
            step(ir, 1'b1, 1'b0, '0);
            n++;
        end
        chk(tag, mem_req_valid, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int h0;
        bit ir, rv;
        logic [63:0] rp;
        lat_cfg = 0; fixed_en = 0; fixed_data = '0;
        #2;
        do_reset();
        // first fetch, single-cycle memory returning a NOP
        fixed_en = 1; fixed_data = 64'h13;
        wait_req("r21_req0", 0, 4);
        chk("r21_addr0", mem_req_addr, RPC);
        step(0, 1, 0, '0);
        step(0, 0, 0, '0);
        chk("r21_inst", inst_out, 32'h13);
        chk("r21_pc", inst_pc, RPC);
        wait_req("r21_req1", 0, 4);
        chk("r21_addr1", mem_req_addr, RPC + 64'd4);
        // stalled consumer: queue fills to depth, then fetching stops; 64-bit word half select
        do_reset();
        fixed_data = 64'hAAAA_AAAA_BBBB_BBBB;
        h0 = n_hs;
        repeat (30) step(0, 1, 0, '0);
        chk("r22_nreq", n_hs - h0, 4);
        chk("r22_cnt", fq_count, 4);
        chk("r22_noreq", mem_req_valid, 0);
        chk("r25_lo", inst_out, 32'hBBBB_BBBB);
        step(1, 0, 0, '0);
        chk("r25_hi", inst_out, 32'hAAAA_AAAA);
        chk("r25_pc", inst_pc, RPC + 64'd4);
        // memory back-pressure holds the request
        do_reset();
        fixed_en = 0;
        step(0, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            chk("r23_v", mem_req_valid, 1);
            chk("r23_a", mem_req_addr, RPC);
            step(0, 0, 0, '0);
        end
        // redirect while waiting for a response
        repeat (8) step(0, 1, 0, '0);
        lat_cfg = 3;
        wait_req("r24_req", 0, 10);
        step(0, 1, 0, '0);
        step(0, 0, 1, 64'h8000_1002);
        chk("r24_cnt", fq_count, 0);
        chk("r24_v", inst_valid, 0);
        wait_req("r24_req2", 0, 12);
        chk("r24_addr", mem_req_addr, 64'h8000_1000);
        // reset while a fetch is outstanding
        step(0, 1, 0, '0);
        do_reset();
        step(0, 1, 0, '0);
        chk("r20_v", mem_req_valid, 1);
        chk("r20_a", mem_req_addr, RPC);
        // randomized traffic with redirects, back-pressure and varying latency
        lat_cfg = -1;
        for (int k = 0; k < 3000; k++) begin
            ir = $urandom_range(0, 99) < (((k / 150) % 2) != 0 ? 85 : 15);
            rv = $urandom_range(0, 99) < 4;
            rp = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            step(ir, $urandom_range(0, 99) < 70, rv, rp);
        end
        chk("cov_enq_deq", n_both > 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
